line_fill_unit: RTL and testbench

Sequences a four-word cache-line refill for the instruction cache. It takes the 14-bit word address of a missing instruction, issues the four word reads of the aligned line (offsets 00, 01, 10, 11 in that order) to the instruction memory one at a time, and packs the returned words into a 128-bit line. It sits between the cache miss logic and the memory port. It is the consumer and sequencer of the line-address set the cache derives for a line: it steps through those addresses serially rather than presenting them all at once.

---
 rtl/line_fill_unit_if.sv | 29 ++
 rtl/line_fill_unit.sv | 84 ++++++++
 tb/tb_line_fill_unit.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_fill_unit_if.sv
// rtl/line_fill_unit_if.sv - miss-side and memory-side signal bundle for the line fill unit
//   master modport: the fill unit (drives mem_rden/mem_addr and the fill results)
//   slave modport : cache miss logic plus instruction memory (drives miss_req/miss_addr/abort/mem_valid/mem_rdata)
interface line_fill_unit_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic                  miss_req;
    logic [ADDR_W-1:0]     miss_addr;
    logic                  abort;
    logic                  mem_rden;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_valid;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  busy;
    logic                  fill_done;
    logic [ADDR_W-3:0]     line_idx;
    logic [4*DATA_W-1:0]   line_data;

    modport master (
        input  miss_req, miss_addr, abort, mem_valid, mem_rdata,
        output mem_rden, mem_addr, busy, fill_done, line_idx, line_data
    );

    modport slave (
        output miss_req, miss_addr, abort, mem_valid, mem_rdata,
        input  mem_rden, mem_addr, busy, fill_done, line_idx, line_data
    );
endinterface

// File: rtl/line_fill_unit.sv
// rtl/line_fill_unit.sv - four-word instruction cache line refill sequencer
//   CLK   : rising-edge clock
//   RST_N : asynchronous active-low reset
//   bus   : line_fill_unit_if.master (miss request/abort in, serial memory reads out,
//           busy/fill_done/line_idx/line_data results out)
module line_fill_unit #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    line_fill_unit_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q,     state_d;
    logic [1:0]            word_cnt_q,  word_cnt_d;
    logic [ADDR_W-3:0]     line_idx_q,  line_idx_d;
    logic [4*DATA_W-1:0]   line_data_q, line_data_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            word_cnt_q  <= 2'd0;
            line_idx_q  <= '0;
            line_data_q <= '0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            line_idx_q  <= line_idx_d;
            line_data_q <= line_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        line_idx_d  = line_idx_q;
        line_data_d = line_data_q;
        case (state_q)
            IDLE: begin
                // abort outranks a simultaneous request; the request is simply lost
                if (!bus.abort && bus.miss_req) begin
                    line_idx_d = bus.miss_addr[ADDR_W-1:2];
                    word_cnt_d = 2'd0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                // abort drops any word arriving in the same cycle; partial data stays unflagged
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.mem_valid) begin
                    line_data_d[DATA_W*int'(word_cnt_q) +: DATA_W] = bus.mem_rdata;
                    // the counter only wraps 3 -> 0 on the way out to DONE
                    word_cnt_d = word_cnt_q + 2'd1;
                    if (word_cnt_q == 2'd3) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // address is forced to zero outside REQ so the port is quiet between fills
    assign bus.mem_rden  = (state_q == REQ);
    assign bus.mem_addr  = (state_q == REQ) ? {line_idx_q, word_cnt_q} : '0;
    assign bus.busy      = (state_q != IDLE);
    assign bus.fill_done = (state_q == DONE) && !bus.abort;
    assign bus.line_idx  = line_idx_q;
    assign bus.line_data = line_data_q;

endmodule

// File: tb/tb_line_fill_unit.sv
// tb/tb_line_fill_unit.sv - self-checking bench for line_fill_unit
module tb_line_fill_unit;

    logic CLK;
    logic RST_N;

    line_fill_unit_if #(.ADDR_W(14), .DATA_W(32)) bus ();

    line_fill_unit #(.ADDR_W(14), .DATA_W(32)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.master)
    );

    int checks   = 0;
    int failures = 0;

    // memory model: word k answers after lat[k] wait cycles, data = salt ^ address
    int          lat [4];
    int          wait_cnt;
    logic [31:0] salt;

    assign bus.mem_valid = bus.mem_rden && (wait_cnt >= lat[bus.mem_addr[1:0]]);
    assign bus.mem_rdata = salt ^ {18'b0, bus.mem_addr};

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) wait_cnt <= 0;
        else        wait_cnt <= (bus.mem_rden && !bus.mem_valid) ? wait_cnt + 1 : 0;
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // observations gathered by watch()
    int           obs_done;
    int           obs_rden;
    bit           obs_busy_gap;
    logic [127:0] obs_data;
    logic [11:0]  obs_idx;
    logic [13:0]  addr_q[$];

    function automatic logic [127:0] exp_line(input logic [13:0] a, input logic [31:0] s);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[32*k +: 32] = s ^ {18'b0, a[13:2], 2'(k)};
        return r;
    endfunction

    task automatic start_fill(input logic [13:0] a);
        @(negedge CLK);
        bus.miss_req  = 1'b1;
        bus.miss_addr = a;
        @(posedge CLK);
        #1 bus.miss_req = 1'b0;
    endtask

    // cycle n is the cycle after acceptance edge n-1; sampled at its negedge
    task automatic watch(input int max_c);
        obs_done = -1; obs_rden = 0; obs_busy_gap = 0;
        addr_q.delete();
        for (int c = 1; c <= max_c && obs_done < 0; c++) begin
            @(negedge CLK);
            if (bus.mem_rden) obs_rden++;
            if (bus.mem_rden && bus.mem_valid) addr_q.push_back(bus.mem_addr);
            if (!bus.busy) obs_busy_gap = 1;
            if (bus.fill_done) begin
                obs_done = c; obs_data = bus.line_data; obs_idx = bus.line_idx;
            end
        end
    endtask

    task automatic run_fill(input string name, input logic [13:0] a,
                            input int l0, input int l1, input int l2, input int l3,
                            input logic [31:0] s);
        int exp_done;
        lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3; salt = s;
        exp_done = 1 + (l0 + 1) + (l1 + 1) + (l2 + 1) + (l3 + 1);
        start_fill(a);
        watch(60);
        checks++;
        if (obs_done !== exp_done) begin
            failures++; $display("FAIL %s done_cycle got=%0d exp=%0d", name, obs_done, exp_done);
        end
        checks++;
        if (obs_idx !== a[13:2]) begin
            failures++; $display("FAIL %s line_idx got=%h exp=%h", name, obs_idx, a[13:2]);
        end
        checks++;
        if (obs_data !== exp_line(a, s)) begin
            failures++; $display("FAIL %s line_data got=%h exp=%h", name, obs_data, exp_line(a, s));
        end
        checks++;
        if (obs_rden !== exp_done - 1 || obs_busy_gap) begin
            failures++; $display("FAIL %s rden_cycles got=%0d exp=%0d busy_gap=%0d", name, obs_rden, exp_done - 1, obs_busy_gap);
        end
        checks++;
        if (addr_q.size() != 4) begin
            failures++; $display("FAIL %s addr_count got=%0d exp=4", name, addr_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (addr_q[k] !== {a[13:2], 2'(k)}) begin
                    failures++; $display("FAIL %s addr%0d got=%h exp=%h", name, k, addr_q[k], {a[13:2], 2'(k)});
                end
            end
        end
        @(negedge CLK);
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        bus.miss_req = 1'b0; bus.miss_addr = '0; bus.abort = 1'b0;
        lat[0] = 1; lat[1] = 1; lat[2] = 1; lat[3] = 1; salt = 32'hA000_0000;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        checks++;
        if ({bus.mem_rden, bus.busy, bus.fill_done} !== 3'b000 || bus.mem_addr !== 14'h0) begin
            failures++; $display("FAIL reset ctrl got rden=%b busy=%b done=%b addr=%h exp all 0", bus.mem_rden, bus.busy, bus.fill_done, bus.mem_addr);
        end
        checks++;
        if (bus.line_idx !== 12'h0 || bus.line_data !== 128'h0) begin
            failures++; $display("FAIL reset data got idx=%h data=%h exp 0", bus.line_idx, bus.line_data);
        end
    endtask

    task automatic test_one_cycle_mem;
        run_fill("one_cycle", 14'h1235, 1, 1, 1, 1, 32'hA000_0000);
    endtask

    task automatic test_zero_latency;
        run_fill("zero_lat", 14'h3FFF, 0, 0, 0, 0, 32'hA000_0000);
    endtask

    task automatic test_stall;
        run_fill("stall_w2", 14'h0842, 1, 1, 3, 1, 32'h5EED_0000);
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++) begin
            run_fill($sformatf("rand%0d", i), 14'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
        end
    endtask

    task automatic test_abort;
        logic [127:0] prev;
        logic [13:0]  a;
        bit           hit;
        int           dones;
        prev = bus.line_data;
        a = 14'h2A58;
        lat[0] = 1; lat[1] = 1; lat[2] = 1; lat[3] = 1; salt = 32'hC0DE_0000;
        start_fill(a);
        hit = 0;
        for (int c = 1; c <= 20 && !hit; c++) begin
            @(negedge CLK);
            if (bus.mem_rden && bus.mem_valid && bus.mem_addr[1:0] == 2'd1) begin
                bus.abort = 1'b1;
                hit = 1;
                @(posedge CLK);
                #1 bus.abort = 1'b0;
            end
        end
        @(negedge CLK);
        checks++;
        if (!hit || bus.busy !== 1'b0 || bus.fill_done !== 1'b0) begin
            failures++; $display("FAIL abort_idle got hit=%0d busy=%b done=%b exp hit=1 busy=0 done=0", hit, bus.busy, bus.fill_done);
        end
        checks++;
        if (bus.line_data[63:32] !== prev[63:32] || bus.line_data[31:0] !== (salt ^ {18'b0, a[13:2], 2'b00})) begin
            failures++; $display("FAIL abort_data got=%h exp w1=%h w0=%h", bus.line_data[63:0], prev[63:32], salt ^ {18'b0, a[13:2], 2'b00});
        end
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            if (bus.fill_done || bus.busy) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++; $display("FAIL abort_quiet got=%0d active cycles exp=0", dones);
        end
        // abort together with miss_req in IDLE: request must be dropped
        bus.abort = 1'b1; bus.miss_req = 1'b1; bus.miss_addr = 14'h1111;
        @(posedge CLK);
        #1 bus.abort = 1'b0; bus.miss_req = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL abort_vs_req got busy=%b exp=0", bus.busy);
        end
        run_fill("after_abort", 14'h2A59, 1, 1, 1, 1, 32'h0BAD_0000);
    endtask

    task automatic test_back_to_back;
        logic [13:0] a0;
        logic [13:0] set_at [0:30];
        int          d0, d1, first2;
        logic [11:0] i0, i1;
        lat[0] = 1; lat[1] = 1; lat[2] = 1; lat[3] = 1; salt = 32'h1357_0000;
        a0 = 14'($urandom);
        d0 = -1; d1 = -1; first2 = -1; i0 = '0; i1 = '0;
        @(negedge CLK);
        bus.miss_req = 1'b1; bus.miss_addr = a0;
        @(posedge CLK);
        for (int c = 1; c <= 30; c++) begin
            @(negedge CLK);
            if (bus.fill_done && d0 < 0) begin d0 = c; i0 = bus.line_idx; end
            else if (bus.fill_done && d1 < 0) begin d1 = c; i1 = bus.line_idx; end
            if (c == 11 && bus.mem_rden) first2 = int'(bus.mem_addr);
            set_at[c] = 14'($urandom);
            bus.miss_addr = set_at[c];
        end
        bus.miss_req = 1'b0;
        checks++;
        if (d0 != 9 || i0 !== a0[13:2]) begin
            failures++; $display("FAIL b2b_first got cyc=%0d idx=%h exp cyc=9 idx=%h", d0, i0, a0[13:2]);
        end
        checks++;
        if (first2 != int'({set_at[10][13:2], 2'b00})) begin
            failures++; $display("FAIL b2b_second_addr got=%h exp=%h", first2, {set_at[10][13:2], 2'b00});
        end
        checks++;
        if (d1 != 19 || i1 !== set_at[10][13:2]) begin
            failures++; $display("FAIL b2b_second got cyc=%0d idx=%h exp cyc=19 idx=%h", d1, i1, set_at[10][13:2]);
        end
        repeat (15) @(negedge CLK);
    endtask

    task automatic test_async_reset;
        bit hit;
        int active;
        lat[0] = 1; lat[1] = 1; lat[2] = 1; lat[3] = 1; salt = 32'hFACE_0000;
        start_fill(14'h0F0C);
        hit = 0;
        for (int c = 1; c <= 20 && !hit; c++) begin
            @(negedge CLK);
            if (bus.mem_rden && bus.mem_addr[1:0] == 2'd2) hit = 1;
        end
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if (!hit || bus.mem_rden !== 1'b0 || bus.busy !== 1'b0 || bus.mem_addr !== 14'h0) begin
            failures++; $display("FAIL async_rst_ctrl got hit=%0d rden=%b busy=%b addr=%h exp hit=1 rest 0", hit, bus.mem_rden, bus.busy, bus.mem_addr);
        end
        checks++;
        if (bus.line_data !== 128'h0 || bus.line_idx !== 12'h0) begin
            failures++; $display("FAIL async_rst_data got data=%h idx=%h exp 0", bus.line_data, bus.line_idx);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        active = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            if (bus.fill_done || bus.busy) active++;
        end
        checks++;
        if (active != 0) begin
            failures++; $display("FAIL async_rst_quiet got=%0d active cycles exp=0", active);
        end
    endtask

    initial begin
        test_reset();
        test_one_cycle_mem();
        test_zero_latency();
        test_stall();
        test_random();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
